ntt_stage_ctrl: RTL and testbench

- Sequencing controller for the NTT core.
- Walks all log2(N) Cooley-Tukey stages and issues one butterfly pair per cycle to the two parallel butterfly units, whose mod_add/mod_sub datapaths are already in the design.
- Per cycle it generates read addresses for both units, twiddle ROM addresses, and write-back addresses delayed to match the datapath latency.
- Sits between the top-level start/done handshake and the coefficient RAM banks.

---
 rtl/ntt_stage_ctrl_pkg.sv | 29 ++
 rtl/ntt_stage_ctrl_addr_gen.sv | 62 ++++++
 rtl/ntt_stage_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared definitions for the NTT stage sequencer.
//
// Contents:
//   - default transform size (LOGN) and pipeline latency;
//   - FSM state encodings (IDLE=0, RUN=1, DRAIN=2, FINISH=3);
//   - stage_bits(): width of the stage index for a given LOGN.
//
// Optional build macro used by the controller: NTT_PERF_CNT_EN
// (enables the 32-bit busy-cycle counter on perf_cycles).

package ntt_stage_ctrl_pkg;

    localparam int unsigned LognDefault    = 8;
    localparam int unsigned NDefault       = 1 << LognDefault;
    localparam int unsigned PipeLatDefault = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StDrain  = 2'd2,
        StFinish = 2'd3
    } state_e;

    // Bits needed to hold a stage index 0..logn-1.
    function automatic int unsigned stage_bits(input int unsigned logn);
        return (logn <= 1) ? 1 : $clog2(logn);
    endfunction

endpackage

// File: rtl/ntt_stage_ctrl_addr_gen.sv
// Combinational butterfly address generator for two parallel units.
//
// For stage s and cycle counter c, unit 0 handles butterfly k = 2c and
// unit 1 handles k = 2c+1:
//   g = k >> s, j = k & (2^s - 1)
//   a = (g << (s+1)) | j, b = a + 2^s
//   twiddle index = j << (LOGN-1-s)
//
// Ports:
//   s        in   stage index
//   c        in   issue counter within the stage
//   a0, b0   out  operand addresses, unit 0
//   a1, b1   out  operand addresses, unit 1
//   tw0, tw1 out  twiddle indices (LOGN-1 bits), unit 0 / unit 1

module ntt_stage_ctrl_addr_gen #(
    parameter int unsigned LOGN = 8,
    parameter int unsigned AW   = LOGN,
    parameter int unsigned SW   = 3,
    parameter int unsigned CW   = LOGN - 2
) (
    input  logic [SW-1:0]   s,
    input  logic [CW-1:0]   c,
    output logic [AW-1:0]   a0,
    output logic [AW-1:0]   b0,
    output logic [AW-1:0]   a1,
    output logic [AW-1:0]   b1,
    output logic [LOGN-2:0] tw0,
    output logic [LOGN-2:0] tw1
);

    logic [AW-1:0]   half;
    logic [AW-1:0]   mask;
    logic [AW-1:0]   k  [2];
    logic [AW-1:0]   j  [2];
    logic [AW-1:0]   g  [2];
    logic [AW-1:0]   a  [2];
    logic [AW-1:0]   b  [2];
    logic [LOGN-2:0] tw [2];

    always_comb begin
        half = AW'(1) << s;
        mask = half - AW'(1);
        for (int u = 0; u < 2; u++) begin
            k[u]  = AW'({c, u[0]});
            j[u]  = k[u] & mask;
            g[u]  = k[u] >> s;
            // Two shifts avoid overflowing s+1 in the narrow stage width.
            a[u]  = ((g[u] << s) << 1) | j[u];
            b[u]  = a[u] + half;
            tw[u] = (LOGN - 1)'(j[u]) << (LOGN - 1 - int'(s));
        end
    end

    assign a0  = a[0];
    assign b0  = b[0];
    assign a1  = a[1];
    assign b1  = b[1];
    assign tw0 = tw[0];
    assign tw1 = tw[1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// NTT stage sequencer: walks all LOGN Cooley-Tukey stages, issuing one
// butterfly pair per cycle to two butterfly units, and delays the read
// addresses by PIPE_LAT cycles to form the write-back addresses.
//
// Optional feature: define NTT_PERF_CNT_EN to enable the 32-bit busy-cycle
// counter on perf_cycles; otherwise perf_cycles is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, inv          start request (IDLE only) and inverse-transform flag
//   hold                freezes issue while in RUN
//   busy, done          RUN/DRAIN indicator, one-cycle completion pulse
//   rd_valid, rd_*      read issue strobe and operand addresses (0 when idle)
//   tw_addr0/1          {latched inv, twiddle index}
//   wr_valid, wr_*      write-back strobe and addresses (PIPE_LAT later)
//   stage               current stage index
//   perf_cycles         busy-cycle count (see NTT_PERF_CNT_EN)

module ntt_stage_ctrl
    import ntt_stage_ctrl_pkg::*;
#(
    parameter int unsigned LOGN     = LognDefault,
    parameter int unsigned PIPE_LAT = PipeLatDefault,
    parameter int unsigned AW       = LOGN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        inv,
    input  logic                        hold,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_valid,
    output logic [AW-1:0]               rd_a0,
    output logic [AW-1:0]               rd_b0,
    output logic [AW-1:0]               rd_a1,
    output logic [AW-1:0]               rd_b1,
    output logic [LOGN-1:0]             tw_addr0,
    output logic [LOGN-1:0]             tw_addr1,
    output logic                        wr_valid,
    output logic [AW-1:0]               wr_a0,
    output logic [AW-1:0]               wr_b0,
    output logic [AW-1:0]               wr_a1,
    output logic [AW-1:0]               wr_b1,
    output logic [stage_bits(LOGN)-1:0] stage,
    output logic [31:0]                 perf_cycles
);

    localparam int unsigned N  = 1 << LOGN;
    localparam int unsigned SW = stage_bits(LOGN);
    localparam int unsigned CW = LOGN - 2;
    localparam int unsigned DW = $clog2(PIPE_LAT + 1);
    localparam int unsigned PW = 1 + 4 * AW;

    localparam logic [CW-1:0] CLast     = CW'(N / 4 - 1);
    localparam logic [SW-1:0] StageLast = SW'(LOGN - 1);
    localparam logic [DW-1:0] DrainLoad = DW'(PIPE_LAT);

    state_e        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [CW-1:0] c_q, c_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          inv_q, inv_d;
    logic          issue;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            c_q     <= '0;
            drain_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            c_q     <= c_d;
            drain_q <= drain_d;
            inv_q   <= inv_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        c_d     = c_q;
        drain_d = drain_q;
        inv_d   = inv_q;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    inv_d   = inv;
                    stage_d = '0;
                    c_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (c_q == CLast) begin
                        drain_d = DrainLoad;
                        state_d = StDrain;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q - DW'(1);
                // Leaving on the count-to-zero cycle puts the stage's last
                // write-back in this cycle, ahead of the next stage's reads.
                if (drain_q == DW'(1)) begin
                    if (stage_q == StageLast) begin
                        state_d = StFinish;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        c_d     = '0;
                        state_d = StRun;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign done     = (state_q == StFinish);
    assign rd_valid = issue;
    assign stage    = stage_q;

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    logic [AW-1:0]   ga0, gb0, ga1, gb1;
    logic [LOGN-2:0] gtw0, gtw1;

    ntt_stage_ctrl_addr_gen #(
        .LOGN (LOGN),
        .AW   (AW),
        .SW   (SW),
        .CW   (CW)
    ) u_addr_gen (
        .s   (stage_q),
        .c   (c_q),
        .a0  (ga0),
        .b0  (gb0),
        .a1  (ga1),
        .b1  (gb1),
        .tw0 (gtw0),
        .tw1 (gtw1)
    );

    // Addresses are zeroed when not issuing so idle outputs read as 0.
    assign rd_a0    = issue ? ga0 : '0;
    assign rd_b0    = issue ? gb0 : '0;
    assign rd_a1    = issue ? ga1 : '0;
    assign rd_b1    = issue ? gb1 : '0;
    assign tw_addr0 = issue ? {inv_q, gtw0} : '0;
    assign tw_addr1 = issue ? {inv_q, gtw1} : '0;

    // ------------------------------------------------------------------
    // Write-back delay line: free-running, not affected by hold
    // ------------------------------------------------------------------
    logic [PW-1:0] pipe_q [PIPE_LAT];
    logic [PW-1:0] pipe_in;

    assign pipe_in = {rd_valid, rd_a0, rd_b0, rd_a1, rd_b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {wr_valid, wr_a0, wr_b0, wr_a1, wr_b1} = pipe_q[PIPE_LAT-1];

    // ------------------------------------------------------------------
    // Busy-cycle counter
    // ------------------------------------------------------------------
`ifdef NTT_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hffff_ffff)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Self-checking bench for ntt_stage_ctrl at LOGN=3, PIPE_LAT=4, AW=3.
// A monitor logs every read issue, write-back and done pulse with its cycle
// number; each run is then compared against a table of hand-computed
// per-issue records (relative cycle, stage, addresses, twiddles).

module tb_ntt_stage_ctrl;

    localparam int unsigned LOGN     = 3;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned AW       = 3;

`ifdef NTT_PERF_CNT_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        inv;
    logic        hold;
    logic        busy;
    logic        done;
    logic        rd_valid;
    logic [2:0]  rd_a0, rd_b0, rd_a1, rd_b1;
    logic [2:0]  tw_addr0, tw_addr1;
    logic        wr_valid;
    logic [2:0]  wr_a0, wr_b0, wr_a1, wr_b1;
    logic [1:0]  stage;
    logic [31:0] perf_cycles;

    ntt_stage_ctrl #(
        .LOGN     (LOGN),
        .PIPE_LAT (PIPE_LAT),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .inv         (inv),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_a0       (rd_a0),
        .rd_b0       (rd_b0),
        .rd_a1       (rd_a1),
        .rd_b1       (rd_b1),
        .tw_addr0    (tw_addr0),
        .tw_addr1    (tw_addr1),
        .wr_valid    (wr_valid),
        .wr_a0       (wr_a0),
        .wr_b0       (wr_b0),
        .wr_a1       (wr_a1),
        .wr_b1       (wr_b1),
        .stage       (stage),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] stg;
        logic [2:0] a0, b0, a1, b1, t0, t1;
    } ev_t;

    // Expected per-issue record: issue cycle (nominal / with hold pattern)
    // relative to the first read, plus stage, addresses and twiddle indices.
    typedef struct {
        int         rel_nom;
        int         rel_hold;
        logic [1:0] stg;
        logic [2:0] a0, b0, a1, b1;
        logic [1:0] t0, t1;
    } vec_t;

    vec_t tbl [6];
    ev_t  rd_q [$];
    ev_t  wr_q [$];
    int   done_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        ev_t e;
        e.cyc = cyc;
        e.stg = stage;
        if (rd_valid) begin
            e.a0 = rd_a0; e.b0 = rd_b0; e.a1 = rd_a1; e.b1 = rd_b1;
            e.t0 = tw_addr0; e.t1 = tw_addr1;
            rd_q.push_back(e);
        end
        if (wr_valid) begin
            e.a0 = wr_a0; e.b0 = wr_b0; e.a1 = wr_a1; e.b1 = wr_b1;
            e.t0 = '0; e.t1 = '0;
            wr_q.push_back(e);
        end
        if (done) done_q.push_back(cyc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full transform. hmask bit r drives hold in relative cycle r;
    // restart_at pulses start again in that relative cycle (-1 = never).
    task automatic run_ntt(input logic inv_v, input logic [39:0] hmask,
                           input int restart_at, output int t0);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        start = 1'b1; inv = inv_v; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; inv = 1'b0;
        t0 = cyc;
        for (int r = 0; r < 40; r++) begin
            hold  = hmask[r];
            start = (r == restart_at);
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        hold = 1'b0; start = 1'b0;
    endtask

    task automatic check_run(input logic inv_v, input bit use_hold, input int t0);
        int rel;
        check("rd_count", rd_q.size(), 6);
        check("wr_count", wr_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            rel = use_hold ? tbl[i].rel_hold : tbl[i].rel_nom;
            if (i < rd_q.size()) begin
                check($sformatf("rd%0d_cycle", i), rd_q[i].cyc - t0, rel);
                check($sformatf("rd%0d_addr", i),
                      {rd_q[i].stg, rd_q[i].a0, rd_q[i].b0, rd_q[i].a1, rd_q[i].b1,
                       rd_q[i].t0, rd_q[i].t1},
                      {tbl[i].stg, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                       inv_v, tbl[i].t0, inv_v, tbl[i].t1});
            end
            if (i < wr_q.size()) begin
                check($sformatf("wr%0d_cycle", i), wr_q[i].cyc - t0, rel + PIPE_LAT);
                check($sformatf("wr%0d_addr", i),
                      {wr_q[i].a0, wr_q[i].b0, wr_q[i].a1, wr_q[i].b1},
                      {tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1});
            end
        end
        check("done_count", done_q.size(), 1);
        if (done_q.size() > 0)
            check("done_latency", done_q[0] - t0, use_hold ? 21 : 18);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;

        tbl[0] = '{0,  0,  2'd0, 3'd0, 3'd1, 3'd2, 3'd3, 2'd0, 2'd0};
        tbl[1] = '{1,  1,  2'd0, 3'd4, 3'd5, 3'd6, 3'd7, 2'd0, 2'd0};
        tbl[2] = '{6,  6,  2'd1, 3'd0, 3'd2, 3'd1, 3'd3, 2'd0, 2'd2};
        tbl[3] = '{7,  10, 2'd1, 3'd4, 3'd6, 3'd5, 3'd7, 2'd0, 2'd2};
        tbl[4] = '{12, 15, 2'd2, 3'd0, 3'd4, 3'd1, 3'd5, 2'd0, 2'd1};
        tbl[5] = '{13, 16, 2'd2, 3'd2, 3'd6, 3'd3, 3'd7, 2'd2, 2'd3};

        rst = 1'b1; start = 1'b0; inv = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_stage", stage, 0);
        check("rst_rd_addr", {rd_a0, rd_b0, rd_a1, rd_b1, tw_addr0, tw_addr1}, 0);
        check("rst_wr_addr", {wr_a0, wr_b0, wr_a1, wr_b1}, 0);
        check("rst_perf", perf_cycles, 0);

        // Nominal forward transform
        run_ntt(1'b0, 40'd0, -1, t0);
        check_run(1'b0, 1'b0, t0);
        @(negedge clk);
        check("perf_nominal", perf_cycles, PerfOn ? 18 : 0);
        repeat (3) @(negedge clk);
        check("perf_held_after_done", perf_cycles, PerfOn ? 18 : 0);

        // Hold in stage 1 RUN (cycles 7..9) and during DRAIN (2, 3, 12)
        run_ntt(1'b0, 40'h0000_0013_8c, -1, t0);
        check_run(1'b0, 1'b1, t0);
        @(negedge clk);
        check("perf_hold", perf_cycles, PerfOn ? 21 : 0);

        // Inverse transform with a stray start in RUN
        run_ntt(1'b1, 40'd0, 1, t0);
        check_run(1'b1, 1'b0, t0);

        // Reset during stage 1 DRAIN (relative cycle 9)
        rd_q.delete(); wr_q.delete(); done_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", busy, 1);
        check("pre_rst_stage", stage, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wr_q.delete(); done_q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_wr_valid", wr_valid, 0);
        check("abort_stage", stage, 0);
        check("abort_done", done, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_q.size(), 0);
        check("abort_no_wr", wr_q.size(), 0);

        // Full run after abort
        run_ntt(1'b0, 40'd0, -1, t0);
        check_run(1'b0, 1'b0, t0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
